// File: rtl/spu_pkg.sv
// spu_pkg: shared sizing constants and FSM state type for the SPU register file.
package spu_pkg;
    localparam int NUM_REGS = 128;
    localparam int DATA_W   = 128;
    localparam int ADDR_W   = 7;
    typedef enum logic {CLEAR, RUN} rf_state_t;
endpackage

// File: rtl/spu_rf_read_port.sv
// spu_rf_read_port: one combinational read port with write-through bypass and zero-forcing while clearing.
module spu_rf_read_port #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clear,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] stored,
    output logic [DATA_W-1:0] data
);
    assign data = clear ? '0 : (wr_en && rd_addr == wr_addr) ? wr_data : stored;
endmodule

// File: rtl/spu_register_file.sv
// spu_register_file: 3-read/1-write SPU register file, zeroed by a one-entry-per-cycle sweep after reset.
import spu_pkg::*;
module spu_register_file #(
    parameter int NUM_REGS = spu_pkg::NUM_REGS,
    parameter int DATA_W   = spu_pkg::DATA_W,
    parameter int ADDR_W   = spu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regWrite_enable,
    input  logic [ADDR_W-1:0] RegisterRT,
    input  logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] RegisterRA,
    input  logic [ADDR_W-1:0] RegisterRB,
    input  logic [ADDR_W-1:0] RegisterRC,
    output logic [DATA_W-1:0] RA_data,
    output logic [DATA_W-1:0] RB_data,
    output logic [DATA_W-1:0] RC_data,
    output logic              clear_busy
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
    logic [DATA_W-1:0] mem [NUM_REGS];
    rf_state_t state, state_next;
    logic [ADDR_W-1:0] clr_cnt, clr_next;
    logic wr_en;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_next;
        end
    end
    // The counter parks at the last entry so RUN never re-enters a sweep.
    always_comb begin
        state_next = state;
        clr_next   = clr_cnt;
        if (state == CLEAR) begin
            clr_next   = (clr_cnt == LAST) ? clr_cnt : clr_cnt + 1'b1;
            state_next = (clr_cnt == LAST) ? RUN : CLEAR;
        end
    end
    assign clear_busy = (state == CLEAR);
    assign wr_en      = regWrite_enable && !clear_busy;
    always_ff @(posedge clk) begin
        if (clear_busy)
            mem[clr_cnt] <= '0;
        else if (wr_en)
            mem[RegisterRT] <= writeData;
    end
    spu_rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
        .clear(clear_busy), .wr_en(wr_en), .wr_addr(RegisterRT), .wr_data(writeData),
        .rd_addr(RegisterRA), .stored(mem[RegisterRA]), .data(RA_data)
    );
    spu_rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
        .clear(clear_busy), .wr_en(wr_en), .wr_addr(RegisterRT), .wr_data(writeData),
        .rd_addr(RegisterRB), .stored(mem[RegisterRB]), .data(RB_data)
    );
    spu_rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_c (
        .clear(clear_busy), .wr_en(wr_en), .wr_addr(RegisterRT), .wr_data(writeData),
        .rd_addr(RegisterRC), .stored(mem[RegisterRC]), .data(RC_data)
    );
endmodule

// File: tb/tb_spu_register_file.sv
// tb_spu_register_file: directed checks of clear sweep, reads, bypass, writes and reset abort.
module tb_spu_register_file;
    logic         clk = 1'b0;
    logic         reset;
    logic         regWrite_enable;
    logic [6:0]   RegisterRT, RegisterRA, RegisterRB, RegisterRC;
    logic [127:0] writeData, RA_data, RB_data, RC_data;
    logic         clear_busy;
    int           total = 0;
    int           passed = 0;
    int           cnt;
    localparam logic [127:0] V5   = 128'hDEADBEEF_00000000_00000000_00000001;
    localparam logic [127:0] VA5  = {16{8'hA5}};
    localparam logic [127:0] V127 = 128'h12345678_9ABCDEF0_12345678_9ABCDEF0;

    spu_register_file dut (
        .clk(clk), .reset(reset), .regWrite_enable(regWrite_enable),
        .RegisterRT(RegisterRT), .writeData(writeData),
        .RegisterRA(RegisterRA), .RegisterRB(RegisterRB), .RegisterRC(RegisterRC),
        .RA_data(RA_data), .RB_data(RB_data), .RC_data(RC_data), .clear_busy(clear_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wr(input logic [6:0] a, input logic [127:0] d);
        regWrite_enable = 1'b1;
        RegisterRT = a;
        writeData = d;
        @(posedge clk); #1;
        regWrite_enable = 1'b0;
    endtask

    task automatic sweep(input string tag);
        cnt = 0;
        while (clear_busy && cnt < 300) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk(tag, 128'(cnt), 128'd128);
    endtask

    initial begin
        reset = 1'b0;
        regWrite_enable = 1'b0;
        RegisterRT = '0; writeData = '0;
        RegisterRA = 7'd5; RegisterRB = 7'd6; RegisterRC = 7'd7;
        #1;
        chk("reset_busy", 128'(clear_busy), 128'd1);
        chk("reset_ra", RA_data, '0);
        chk("reset_rb", RB_data, '0);
        chk("reset_rc", RC_data, '0);
        @(negedge clk);
        reset = 1'b1;
        // Write attempt during the sweep must be ignored and not bypassed.
        regWrite_enable = 1'b1; RegisterRT = 7'd3; writeData = '1; RegisterRA = 7'd3;
        #1;
        chk("clear_no_bypass", RA_data, '0);
        sweep("sweep_len");
        regWrite_enable = 1'b0;
        chk("run_busy", 128'(clear_busy), 128'd0);
        RegisterRA = 7'd0; RegisterRB = 7'd64; RegisterRC = 7'd127;
        #1;
        chk("zero_0", RA_data, '0);
        chk("zero_64", RB_data, '0);
        chk("zero_127", RC_data, '0);
        RegisterRA = 7'd3;
        #1;
        chk("ignored_write_3", RA_data, '0);
        wr(7'd5, V5);
        RegisterRA = 7'd5; RegisterRB = 7'd6;
        #1;
        chk("read_5", RA_data, V5);
        chk("read_6", RB_data, '0);
        regWrite_enable = 1'b1; RegisterRT = 7'd9; writeData = VA5;
        RegisterRA = 7'd9; RegisterRB = 7'd9; RegisterRC = 7'd9;
        #1;
        chk("bypass_a", RA_data, VA5);
        chk("bypass_b", RB_data, VA5);
        chk("bypass_c", RC_data, VA5);
        RegisterRC = 7'd5;
        #1;
        chk("no_bypass_c", RC_data, V5);
        @(posedge clk); #1;
        regWrite_enable = 1'b0;
        #1;
        chk("stored_9", RA_data, VA5);
        regWrite_enable = 1'b1; RegisterRT = 7'd0; writeData = 128'h1; RegisterRA = 7'd0;
        @(posedge clk); #1;
        writeData = 128'h2;
        @(posedge clk); #1;
        regWrite_enable = 1'b0;
        #1;
        chk("last_write_0", RA_data, 128'h2);
        repeat (200) @(posedge clk);
        #1;
        chk("no_second_sweep", 128'(clear_busy), 128'd0);
        RegisterRA = 7'd5;
        #1;
        chk("keep_5", RA_data, V5);
        wr(7'd127, V127);
        RegisterRA = 7'd127;
        #1;
        chk("read_127", RA_data, V127);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", 128'(clear_busy), 128'd1);
        chk("abort_ra", RA_data, '0);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("resweep_busy", 128'(clear_busy), 128'd1);
        sweep("resweep_len");
        #1;
        chk("cleared_127", RA_data, '0);
        RegisterRA = 7'd5; RegisterRB = 7'd9; RegisterRC = 7'd0;
        #1;
        chk("cleared_5", RA_data, '0);
        chk("cleared_9", RB_data, '0);
        chk("cleared_0", RC_data, '0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/spu_register_file.md
SPU_REGISTER_FILE -- requirements
Module: spu_register_file

Interface
REQ-001 Parameter NUM_REGS, default 128, number of 128-bit architectural registers.
REQ-002 Parameter DATA_W, default 128, register width in bits.
REQ-003 Parameter ADDR_W, default 7, register address width.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 regWrite_enable  input  1  write request from the MEM/WB writeback stage.
REQ-007 RegisterRT  input  ADDR_W  write address from writeback.
REQ-008 writeData  input  DATA_W  write data from the writeback mem-to-reg select.
REQ-009 RegisterRA / RegisterRB / RegisterRC  input  ADDR_W each  read addresses, ports A/B/C.
REQ-010 RA_data / RB_data / RC_data  output  DATA_W each  read data, ports A/B/C.
REQ-011 clear_busy  output  1  high while the zero-clear sweep runs; decode stalls on it.

Function
REQ-012 The block SHALL have a two-state FSM: CLEAR and RUN.
REQ-013 In CLEAR, each cycle SHALL write zero to the entry at clr_cnt (ADDR_W bits), then increment clr_cnt.
REQ-014 When clr_cnt = NUM_REGS-1 in CLEAR, the next state SHALL be RUN; the sweep lasts exactly NUM_REGS cycles after reset release.
REQ-015 clear_busy SHALL be 1 iff state = CLEAR.
REQ-016 In CLEAR, regWrite_enable SHALL be ignored, with no write and no bypass.
REQ-017 In CLEAR, all three read outputs SHALL be 0.
REQ-018 In RUN, when regWrite_enable = 1, entry RegisterRT SHALL take writeData at posedge clk.
REQ-019 In RUN, reads SHALL be combinational (zero latency) from the addressed entry.
REQ-020 In RUN, when regWrite_enable = 1 and a read address equals RegisterRT, that port SHALL return writeData in the same cycle (write-through bypass).
REQ-021 Any number of ports reading the same address SHALL all return the same value, including the bypassed value.
REQ-022 No register is hardwired; address 0 SHALL be writable like any other.
REQ-023 clr_cnt SHALL stop at NUM_REGS-1 and SHALL NOT wrap into a second sweep.
REQ-024 A write to the same address on consecutive cycles SHALL leave the last value written.

Reset
REQ-025 While reset = 0, state SHALL be CLEAR, clr_cnt SHALL be 0, clear_busy SHALL be 1, and RA_data/RB_data/RC_data SHALL be 0.
REQ-026 Asserting reset mid-sweep or during RUN SHALL abort immediately, asynchronously; after release the full NUM_REGS-cycle sweep SHALL restart from entry 0.
REQ-027 The storage array SHALL NOT be reset directly; it is zeroed only by the sweep.

Structure
REQ-028 The shared package spu_pkg SHALL hold NUM_REGS, DATA_W, ADDR_W and the enum rf_state_t {CLEAR, RUN}.
REQ-029 One sub-module, spu_rf_read_port, SHALL implement address compare, bypass select and CLEAR zero-forcing, and SHALL be instantiated three times.
REQ-030 The storage array, FSM and clr_cnt SHALL reside in spu_register_file.

Verification
REQ-031 Scenario 1: release reset and count cycles -> clear_busy = 1 for exactly 128 posedges, then 0; reading entries 0, 64 and 127 returns 0.
REQ-032 Scenario 2: in RUN, write RT=5 with 0xDEADBEEF_..._0001, then read RA=5 next cycle -> RA_data = written value; RB=6 reads 0.
REQ-033 Scenario 3: same cycle, write RT=9 with 0xA5A5...A5 while RA=RB=RC=9 -> all three outputs = 0xA5A5...A5 before the posedge.
REQ-034 Scenario 4: drive regWrite_enable=1, RT=3, data=0xFF..FF during the sweep; read RA=3 after RUN -> 0.
REQ-035 Scenario 5: write RT=127 = 0x1234..., assert reset for 1 cycle mid-RUN -> clear_busy = 1 at once; after a 128-cycle sweep RA=127 reads 0.
REQ-036 Scenario 6: write RT=0 = 0x1 then RT=0 = 0x2 on back-to-back cycles -> RA=0 reads 0x2.
